// File: rtl/hbmc_arb_pkg.sv
// Shared types and response codes for the HBMC AXI arbiter.
package hbmc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    WR_ACK = 3'd3,
    RD_REQ = 3'd4,
    RD_RSP = 3'd5,
    RD_ACK = 3'd6
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

endpackage

// File: rtl/hbmc_rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins.
module hbmc_rr_arbiter
  import hbmc_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int PtrW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic              found,
  output logic [PtrW-1:0]   next_ptr
);

  logic [PtrW-1:0] cand;
  logic            hit;

  // (base + off) mod NumReq for off < NumReq
  function automatic logic [PtrW-1:0] wrap(input logic [PtrW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= NumReq) ? PtrW'(sum - NumReq) : PtrW'(sum);
  endfunction

  // Scan requesters starting at the pointer, keep the first hit
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    next_ptr = ptr;
    cand     = ptr;
    hit      = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand        = wrap(ptr, i);
      hit         = !found && req[cand];
      grant[cand] = grant[cand] | hit;
      next_ptr    = hit ? wrap(cand, 1) : next_ptr;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/hbmc_axi_arbiter.sv
// Shares the single-beat HBMC AXI slave port between NumReq requesters:
// round-robin grant, one transaction in flight, response watchdog with drain.
module hbmc_axi_arbiter
  import hbmc_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 4096
) (
  input  logic                              clk_peri_i,
  input  logic                              rst_peri_ni,
  input  logic [NumReq-1:0]                 s_awvalid_i,
  output logic [NumReq-1:0]                 s_awready_o,
  input  logic [NumReq*AddrWidth-1:0]       s_awaddr_i,
  input  logic [NumReq-1:0]                 s_wvalid_i,
  output logic [NumReq-1:0]                 s_wready_o,
  input  logic [NumReq*DataWidth-1:0]       s_wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0]   s_wstrb_i,
  output logic [NumReq-1:0]                 s_bvalid_o,
  input  logic [NumReq-1:0]                 s_bready_i,
  output logic [1:0]                        s_bresp_o,
  input  logic [NumReq-1:0]                 s_arvalid_i,
  output logic [NumReq-1:0]                 s_arready_o,
  input  logic [NumReq*AddrWidth-1:0]       s_araddr_i,
  output logic [NumReq-1:0]                 s_rvalid_o,
  input  logic [NumReq-1:0]                 s_rready_i,
  output logic [DataWidth-1:0]              s_rdata_o,
  output logic [1:0]                        s_rresp_o,
  output logic                              m_awvalid_o,
  input  logic                              m_awready_i,
  output logic [AddrWidth-1:0]              m_awaddr_o,
  output logic                              m_wvalid_o,
  input  logic                              m_wready_i,
  output logic [DataWidth-1:0]              m_wdata_o,
  output logic [DataWidth/8-1:0]            m_wstrb_o,
  input  logic                              m_bvalid_i,
  output logic                              m_bready_o,
  input  logic [1:0]                        m_bresp_i,
  output logic                              m_arvalid_o,
  input  logic                              m_arready_i,
  output logic [AddrWidth-1:0]              m_araddr_o,
  input  logic                              m_rvalid_i,
  output logic                              m_rready_o,
  input  logic [DataWidth-1:0]              m_rdata_i,
  input  logic [1:0]                        m_rresp_i,
  output logic [NumReq-1:0]                 grant_o,
  output logic                              timeout_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int PtrW      = $clog2(NumReq);
  localparam int CntW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit WdEnable  = (TimeoutCycles > 0);
  localparam logic [CntW-1:0] WdLimit = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  state_e                state, next_state;
  logic [PtrW-1:0]       ptr, next_ptr;
  logic [NumReq-1:0]     wr_req, any_req, arb_grant, grant;
  logic                  arb_found, can_grant, sel_wr, wr_req_done, wd_hit;
  logic                  aw_pend, w_pend, ar_pend, drain_w, drain_r, timeout;
  logic [AddrWidth-1:0]  sel_awaddr, sel_araddr, addr;
  logic [DataWidth-1:0]  sel_wdata, wdata, rdata;
  logic [StrbWidth-1:0]  sel_wstrb, wstrb;
  logic [1:0]            resp;
  logic [CntW-1:0]       wd_cnt;

  // A write needs both address and data valid; write wins over read per requester
  assign wr_req  = s_awvalid_i & s_wvalid_i;
  assign any_req = wr_req | s_arvalid_i;

  hbmc_rr_arbiter #(.NumReq(NumReq), .PtrW(PtrW)) u_rr (
    .req      (any_req),
    .ptr      (ptr),
    .grant    (arb_grant),
    .found    (arb_found),
    .next_ptr (next_ptr)
  );

  // Select the winning requester's payload (grant is one-hot)
  always_comb begin
    sel_awaddr = '0;
    sel_araddr = '0;
    sel_wdata  = '0;
    sel_wstrb  = '0;
    for (int k = 0; k < NumReq; k++) begin
      sel_awaddr = sel_awaddr | ({AddrWidth{arb_grant[k]}} & s_awaddr_i[k*AddrWidth +: AddrWidth]);
      sel_araddr = sel_araddr | ({AddrWidth{arb_grant[k]}} & s_araddr_i[k*AddrWidth +: AddrWidth]);
      sel_wdata  = sel_wdata  | ({DataWidth{arb_grant[k]}} & s_wdata_i[k*DataWidth +: DataWidth]);
      sel_wstrb  = sel_wstrb  | ({StrbWidth{arb_grant[k]}} & s_wstrb_i[k*StrbWidth +: StrbWidth]);
    end
  end

  // A pending drain means memory still owes a response; hold off new grants
  assign can_grant   = (state == IDLE) && !drain_w && !drain_r && arb_found;
  assign sel_wr      = |(arb_grant & wr_req);
  assign wd_hit      = WdEnable && (wd_cnt == WdLimit);
  assign wr_req_done = (!aw_pend || m_awready_i) && (!w_pend || m_wready_i);

  // Requester-side readies are a one-cycle combinational pulse in the grant cycle
  assign s_awready_o = (rst_peri_ni && can_grant && sel_wr)  ? arb_grant : '0;
  assign s_wready_o  = (rst_peri_ni && can_grant && sel_wr)  ? arb_grant : '0;
  assign s_arready_o = (rst_peri_ni && can_grant && !sel_wr) ? arb_grant : '0;
  assign s_bvalid_o  = (state == WR_ACK) ? grant : '0;
  assign s_rvalid_o  = (state == RD_ACK) ? grant : '0;
  assign s_bresp_o   = resp;
  assign s_rresp_o   = resp;
  assign s_rdata_o   = rdata;

  assign m_awvalid_o = aw_pend;
  assign m_wvalid_o  = w_pend;
  assign m_arvalid_o = ar_pend;
  assign m_awaddr_o  = addr;
  assign m_araddr_o  = addr;
  assign m_wdata_o   = wdata;
  assign m_wstrb_o   = wstrb;
  assign m_bready_o  = (state == WR_RSP) || drain_w;
  assign m_rready_o  = (state == RD_RSP) || drain_r;
  assign grant_o     = grant;
  assign timeout_o   = timeout;

  // State register
  always_ff @(posedge clk_peri_i or negedge rst_peri_ni) begin
    if (!rst_peri_ni) state <= IDLE;
    else              state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (can_grant) next_state = sel_wr ? WR_REQ : RD_REQ;
               else           next_state = IDLE;
      WR_REQ:  if (wr_req_done) next_state = WR_RSP;
               else             next_state = WR_REQ;
      WR_RSP:  if (m_bvalid_i || wd_hit) next_state = WR_ACK;
               else                      next_state = WR_RSP;
      WR_ACK:  if (|(s_bready_i & grant)) next_state = IDLE;
               else                       next_state = WR_ACK;
      RD_REQ:  if (m_arready_i) next_state = RD_RSP;
               else             next_state = RD_REQ;
      RD_RSP:  if (m_rvalid_i || wd_hit) next_state = RD_ACK;
               else                      next_state = RD_RSP;
      RD_ACK:  if (|(s_rready_i & grant)) next_state = IDLE;
               else                       next_state = RD_ACK;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: grant/payload capture, manager valids, watchdog, drain tracking
  always_ff @(posedge clk_peri_i or negedge rst_peri_ni) begin
    if (!rst_peri_ni) begin
      ptr     <= '0;
      grant   <= '0;
      addr    <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      rdata   <= '0;
      resp    <= RespOkay;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
      wd_cnt  <= '0;
      drain_w <= 1'b0;
      drain_r <= 1'b0;
      timeout <= 1'b0;
    end else begin
      // A late response to an abandoned transaction is swallowed here
      if (drain_w && m_bvalid_i) drain_w <= 1'b0;
      if (drain_r && m_rvalid_i) drain_r <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            grant   <= arb_grant;
            ptr     <= next_ptr;
            addr    <= sel_wr ? sel_awaddr : sel_araddr;
            wdata   <= sel_wdata;
            wstrb   <= sel_wstrb;
            aw_pend <= sel_wr;
            w_pend  <= sel_wr;
            ar_pend <= !sel_wr;
          end
        end
        WR_REQ: begin
          wd_cnt <= '0;
          if (m_awready_i) aw_pend <= 1'b0;
          if (m_wready_i)  w_pend  <= 1'b0;
        end
        WR_RSP: begin
          if (m_bvalid_i) begin
            resp <= m_bresp_i;
          end else if (wd_hit) begin
            resp    <= RespSlvErr;
            timeout <= 1'b1;
            drain_w <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CntW'(1);
          end
        end
        WR_ACK: if (|(s_bready_i & grant)) grant <= '0;
        RD_REQ: begin
          wd_cnt <= '0;
          if (m_arready_i) ar_pend <= 1'b0;
        end
        RD_RSP: begin
          if (m_rvalid_i) begin
            resp  <= m_rresp_i;
            rdata <= m_rdata_i;
          end else if (wd_hit) begin
            resp    <= RespSlvErr;
            rdata   <= '0;
            timeout <= 1'b1;
            drain_r <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CntW'(1);
          end
        end
        RD_ACK: if (|(s_rready_i & grant)) grant <= '0;
        default: grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hbmc_axi_arbiter.sv
// Directed self-checking bench for hbmc_axi_arbiter (NumReq=2, TimeoutCycles=16).
module tb_hbmc_axi_arbiter;
  localparam int NumReq        = 2;
  localparam int AddrWidth     = 32;
  localparam int DataWidth     = 32;
  localparam int StrbWidth     = DataWidth / 8;
  localparam int TimeoutCycles = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NumReq-1:0]           s_awvalid = '0, s_wvalid = '0, s_bready = '0, s_arvalid = '0, s_rready = '0;
  logic [NumReq-1:0]           s_awready, s_wready, s_bvalid, s_arready, s_rvalid, grant;
  logic [NumReq*AddrWidth-1:0] s_awaddr = '0, s_araddr = '0;
  logic [NumReq*DataWidth-1:0] s_wdata = '0;
  logic [NumReq*StrbWidth-1:0] s_wstrb = '0;
  logic [1:0]                  s_bresp, s_rresp;
  logic [DataWidth-1:0]        s_rdata;
  logic                        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, timeout;
  logic                        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic                        m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [1:0]                  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [DataWidth-1:0]        m_rdata = '0, m_wdata;
  logic [StrbWidth-1:0]        m_wstrb;
  logic [AddrWidth-1:0]        m_awaddr, m_araddr;

  int total = 0;
  int bad   = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;

  hbmc_axi_arbiter #(
    .NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_peri_i(clk), .rst_peri_ni(rst_n),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready), .s_awaddr_i(s_awaddr),
    .s_wvalid_i(s_wvalid), .s_wready_o(s_wready), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb),
    .s_bvalid_o(s_bvalid), .s_bready_i(s_bready), .s_bresp_o(s_bresp),
    .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_araddr_i(s_araddr),
    .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rdata_o(s_rdata), .s_rresp_o(s_rresp),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Count manager-side handshakes as seen at each rising edge
  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
    if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
    if (m_arvalid && m_arready) ar_hs <= ar_hs + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NumReq-1:0] oh(input int k);
    logic [NumReq-1:0] one;
    one = {{(NumReq-1){1'b0}}, 1'b1};
    return one << k;
  endfunction

  task automatic set_wr(input int k, input logic [31:0] a, input logic [31:0] d);
    s_awvalid[k] = 1'b1;
    s_wvalid[k]  = 1'b1;
    s_awaddr[k*AddrWidth +: AddrWidth] = a;
    s_wdata[k*DataWidth +: DataWidth]  = d;
    s_wstrb[k*StrbWidth +: StrbWidth]  = 4'hF;
  endtask

  task automatic drop_wr(input int k);
    s_awvalid[k] = 1'b0;
    s_wvalid[k]  = 1'b0;
  endtask

  // Memory side of AW/W: readies rise after the given number of valid cycles
  task automatic mem_aw_w(input int aw_lat, input int w_lat);
    int n;
    bit aw_done, w_done;
    n = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && n < 64) begin
      m_awready = m_awvalid && (n >= aw_lat);
      m_wready  = m_wvalid && (n >= w_lat);
      @(negedge clk);
      if (m_awready) aw_done = 1'b1;
      if (m_wready)  w_done  = 1'b1;
      n++;
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    check_val("aw_w_done", {aw_done, w_done}, 2'b11);
  endtask

  task automatic mem_ar(input int lat, output int cycles);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < 64) begin
      m_arready = m_arvalid && (n >= lat);
      @(negedge clk);
      if (m_arready) done = 1'b1;
      n++;
    end
    m_arready = 1'b0;
    cycles = n;
    check_val("ar_done", done, 1'b1);
  endtask

  task automatic mem_b(input logic [1:0] r);
    check_val("m_bready", m_bready, 1'b1);
    m_bvalid = 1'b1; m_bresp = r;
    @(negedge clk);
    m_bvalid = 1'b0;
  endtask

  task automatic mem_r(input logic [31:0] d, input logic [1:0] r);
    check_val("m_rready", m_rready, 1'b1);
    m_rvalid = 1'b1; m_rdata = d; m_rresp = r;
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic ack_b(input int k);
    s_bready[k] = 1'b1;
    @(negedge clk);
    s_bready[k] = 1'b0;
    check_val("b_drop", s_bvalid, '0);
    check_val("gnt_idle_w", grant, '0);
  endtask

  task automatic ack_r(input int k);
    s_rready[k] = 1'b1;
    @(negedge clk);
    s_rready[k] = 1'b0;
    check_val("r_drop", s_rvalid, '0);
    check_val("gnt_idle_r", grant, '0);
  endtask

  // Finish an already-granted write with zero-latency memory and the given bresp
  task automatic write_tail(input int k, input logic [1:0] r);
    mem_aw_w(0, 0);
    mem_b(r);
    check_val("bvalid", s_bvalid, oh(k));
    check_val("bresp", s_bresp, r);
    ack_b(k);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, aw0, w0, ar0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    check_val("rst_svalid", {s_bvalid, s_rvalid}, '0);
    check_val("rst_grant", grant, '0);
    check_val("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous writes: req0, then req1, then req0's repeat
    set_wr(0, 32'h0000_0100, 32'h1111_0000);
    set_wr(1, 32'h0000_0200, 32'h2222_0000);
    #1 check_val("rr0_awready", s_awready, 2'b01);
    check_val("rr0_wready", s_wready, 2'b01);
    @(negedge clk);
    drop_wr(0);
    check_val("rr0_grant", grant, 2'b01);
    check_val("rr0_addr", m_awaddr, 32'h0000_0100);
    mem_aw_w(0, 0);
    check_val("busy_awready", s_awready, 2'b00);
    mem_b(2'b00);
    check_val("rr0_bvalid", s_bvalid, 2'b01);
    ack_b(0);
    set_wr(0, 32'h0000_0104, 32'h1111_0001);
    #1 check_val("rr1_awready", s_awready, 2'b10);
    @(negedge clk);
    drop_wr(1);
    check_val("rr1_grant", grant, 2'b10);
    check_val("rr1_addr", m_awaddr, 32'h0000_0200);
    check_val("rr1_data", m_wdata, 32'h2222_0000);
    write_tail(1, 2'b01);
    #1 check_val("rr2_awready", s_awready, 2'b01);
    @(negedge clk);
    drop_wr(0);
    check_val("rr2_grant", grant, 2'b01);
    check_val("rr2_addr", m_awaddr, 32'h0000_0104);
    write_tail(0, 2'b00);

    // Single write from req0
    aw0 = aw_hs; w0 = w_hs;
    set_wr(0, 32'h0000_0010, 32'hA5A5_0001);
    #1 check_val("w1_awready", s_awready, 2'b01);
    check_val("w1_arready", s_arready, 2'b00);
    @(negedge clk);
    drop_wr(0);
    check_val("w1_grant", grant, 2'b01);
    check_val("w1_valids", {m_awvalid, m_wvalid}, 2'b11);
    check_val("w1_addr", m_awaddr, 32'h0000_0010);
    check_val("w1_data", m_wdata, 32'hA5A5_0001);
    check_val("w1_strb", m_wstrb, 4'hF);
    write_tail(0, 2'b00);
    check_val("w1_aw_once", aw_hs - aw0, 1);
    check_val("w1_w_once", w_hs - w0, 1);

    // Read from req1 with slow arready
    ar0 = ar_hs;
    s_arvalid[1] = 1'b1;
    s_araddr[AddrWidth +: AddrWidth] = 32'h0000_0020;
    #1 check_val("r1_arready", s_arready, 2'b10);
    @(negedge clk);
    s_arvalid[1] = 1'b0;
    check_val("r1_grant", grant, 2'b10);
    check_val("r1_addr", m_araddr, 32'h0000_0020);
    mem_ar(3, cyc);
    check_val("r1_ar_cycles", cyc, 4);
    check_val("r1_ar_once", ar_hs - ar0, 1);
    check_val("r1_arvalid_low", m_arvalid, 1'b0);
    mem_r(32'hDEAD_BEEF, 2'b00);
    check_val("r1_rvalid", s_rvalid, 2'b10);
    check_val("r1_rdata", s_rdata, 32'hDEAD_BEEF);
    check_val("r1_rresp", s_rresp, 2'b00);
    ack_r(1);

    // W accepted a cycle before AW, then both in the same cycle
    aw0 = aw_hs; w0 = w_hs;
    set_wr(0, 32'h0000_0030, 32'h0BAD_0001);
    @(negedge clk);
    drop_wr(0);
    mem_aw_w(1, 0);
    check_val("split_aw", aw_hs - aw0, 1);
    check_val("split_w", w_hs - w0, 1);
    mem_b(2'b00);
    check_val("split_bvalid", s_bvalid, 2'b01);
    ack_b(0);
    aw0 = aw_hs; w0 = w_hs;
    set_wr(0, 32'h0000_0034, 32'h0BAD_0002);
    @(negedge clk);
    drop_wr(0);
    write_tail(0, 2'b00);
    check_val("same_aw", aw_hs - aw0, 1);
    check_val("same_w", w_hs - w0, 1);

    // Watchdog: no bresp, SLVERR after 16 cycles, late bresp drained before next grant
    set_wr(0, 32'h0000_0300, 32'h5555_AAAA);
    @(negedge clk);
    drop_wr(0);
    mem_aw_w(0, 0);
    n = 0;
    while (s_bvalid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("wd_cycles", n, 16);
    check_val("wd_bvalid", s_bvalid, 2'b01);
    check_val("wd_bresp", s_bresp, 2'b10);
    check_val("wd_timeout", timeout, 1'b1);
    check_val("wd_drain_rdy", m_bready, 1'b1);
    ack_b(0);
    set_wr(1, 32'h0000_0400, 32'h6666_0000);
    #1 check_val("drain_hold", s_awready, 2'b00);
    @(negedge clk);
    check_val("drain_nogrant", grant, 2'b00);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge clk);
    m_bvalid = 1'b0;
    #1 check_val("drain_quiet", s_bvalid, 2'b00);
    check_val("drain_bready", m_bready, 1'b0);
    check_val("drain_regrant", s_awready, 2'b10);
    @(negedge clk);
    drop_wr(1);
    check_val("post_drain_grant", grant, 2'b10);
    write_tail(1, 2'b00);
    check_val("timeout_sticky", timeout, 1'b1);

    // Reset in RD_RSP, then a clean read from pointer 0
    s_arvalid[0] = 1'b1;
    s_araddr[0 +: AddrWidth] = 32'h0000_0040;
    @(negedge clk);
    s_arvalid[0] = 1'b0;
    check_val("rr_grant", grant, 2'b01);
    mem_ar(0, cyc);
    check_val("rr_rready", m_rready, 1'b1);
    s_arvalid[1] = 1'b1;
    s_araddr[AddrWidth +: AddrWidth] = 32'h0000_0080;
    #2 rst_n = 1'b0;
    #1 check_val("ar_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    check_val("ar_readies", {s_awready, s_wready, s_arready}, '0);
    check_val("ar_grant", grant, '0);
    check_val("ar_timeout", timeout, 1'b0);
    @(negedge clk);
    s_arvalid[0] = 1'b1;
    s_araddr[0 +: AddrWidth] = 32'h0000_0044;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("ar_ptr0", s_arready, 2'b01);
    @(negedge clk);
    s_arvalid = '0;
    check_val("ar2_grant", grant, 2'b01);
    check_val("ar2_addr", m_araddr, 32'h0000_0044);
    mem_ar(0, cyc);
    check_val("ar2_cycles", cyc, 1);
    mem_r(32'h1234_5678, 2'b00);
    check_val("ar2_rvalid", s_rvalid, 2'b01);
    check_val("ar2_rdata", s_rdata, 32'h1234_5678);
    ack_r(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
